// File: rtl/ctrl_decode_stage_if.sv
// Handshake and control-bundle bus for ctrl_decode_stage.
// master = upstream/fetch + downstream ready driver, slave = decode stage.
interface ctrl_decode_stage_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUCTRL_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_reg_write;
  logic                 out_alu_src1;
  logic                 out_alu_src2;
  logic [1:0]           out_mem_write;
  logic [2:0]           out_mem_read;
  logic [1:0]           out_result_src;
  logic [2:0]           out_br_type;
  logic [ALUCTRL_W-1:0] out_alu_control;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [XLEN-1:0]      out_pc;
  logic                 out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_reg_write, out_alu_src1, out_alu_src2,
           out_mem_write, out_mem_read, out_result_src, out_br_type,
           out_alu_control, out_rd, out_rs1, out_rs2, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_reg_write, out_alu_src1, out_alu_src2,
           out_mem_write, out_mem_read, out_result_src, out_br_type,
           out_alu_control, out_rd, out_rs1, out_rs2, out_pc, out_illegal
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer (main + skid).
// Define RV32M_EN to decode the M-extension (funct7=0000001) to ALU codes 11-18.
module ctrl_decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUCTRL_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  ctrl_decode_stage_if.slave bus
);

  typedef struct packed {
    logic                 reg_write;
    logic                 alu_src1;
    logic                 alu_src2;
    logic [1:0]           mem_write;
    logic [2:0]           mem_read;
    logic [1:0]           result_src;
    logic [2:0]           br_type;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [XLEN-1:0]      pc;
    logic                 illegal;
  } bundle_t;

  typedef enum logic [1:0] {S_EMPTY, S_MAIN, S_FULL} state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_LUI  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(10);
`ifdef RV32M_EN
  localparam logic [ALUCTRL_W-1:0] ALU_MUL  = ALUCTRL_W'(11);
`endif

  logic [6:0]           w_op;
  logic [2:0]           w_f3;
  logic [6:0]           w_f7;
  logic [ALUCTRL_W-1:0] w_alu_f3;
  logic                 w_bad;
  bundle_t              w_dec;

  state_t  r_state;
  state_t  w_state_nxt;
  bundle_t r_main;
  bundle_t r_skid;
  logic    w_accept;
  logic    w_pop;
  logic    w_load_main_in;
  logic    w_load_main_skid;
  logic    w_load_skid;

  assign w_op = bus.in_instr[6:0];
  assign w_f3 = bus.in_instr[14:12];
  assign w_f7 = bus.in_instr[31:25];

  always_comb begin
    w_dec    = '0;
    w_bad    = 1'b0;
    w_alu_f3 = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu_f3 = ALU_ADD;
      3'b001:  w_alu_f3 = ALU_SLL;
      3'b010:  w_alu_f3 = ALU_SLT;
      3'b011:  w_alu_f3 = ALU_SLTU;
      3'b100:  w_alu_f3 = ALU_XOR;
      3'b101:  w_alu_f3 = ALU_SRL;
      3'b110:  w_alu_f3 = ALU_OR;
      default: w_alu_f3 = ALU_AND;
    endcase

    case (w_op)
      OPC_OP: begin
        w_dec.reg_write = 1'b1;
        if (w_f7 == 7'h00)                          w_dec.alu_control = w_alu_f3;
        else if (w_f7 == 7'h20 && w_f3 == 3'b000)   w_dec.alu_control = ALU_SUB;
        else if (w_f7 == 7'h20 && w_f3 == 3'b101)   w_dec.alu_control = ALU_SRA;
`ifdef RV32M_EN
        else if (w_f7 == 7'h01)                     w_dec.alu_control = ALU_MUL + ALUCTRL_W'(w_f3);
`endif
        else                                        w_bad = 1'b1;
      end
      OPC_OPIMM: begin
        // funct7 is only meaningful for the shift-immediates; addi never subtracts
        w_dec.reg_write = 1'b1;
        w_dec.alu_src2  = 1'b1;
        if (w_f3 == 3'b001) begin
          if (w_f7 == 7'h00) w_dec.alu_control = ALU_SLL;
          else               w_bad = 1'b1;
        end else if (w_f3 == 3'b101) begin
          if (w_f7 == 7'h00)      w_dec.alu_control = ALU_SRL;
          else if (w_f7 == 7'h20) w_dec.alu_control = ALU_SRA;
          else                    w_bad = 1'b1;
        end else begin
          w_dec.alu_control = w_alu_f3;
        end
      end
      OPC_AUIPC: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src1  = 1'b1;
        w_dec.alu_src2  = 1'b1;
      end
      OPC_LUI: begin
        w_dec.reg_write   = 1'b1;
        w_dec.alu_src2    = 1'b1;
        w_dec.alu_control = ALU_LUI;
      end
      OPC_JAL: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src1   = 1'b1;
        w_dec.alu_src2   = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.br_type    = 3'b111;
      end
      OPC_JALR: begin
        w_bad            = (w_f3 != 3'b000);
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src2   = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.br_type    = 3'b111;
      end
      OPC_BRANCH: begin
        w_dec.alu_src1 = 1'b1;
        w_dec.alu_src2 = 1'b1;
        case (w_f3)
          3'b000:  w_dec.br_type = 3'b001;
          3'b001:  w_dec.br_type = 3'b010;
          3'b100:  w_dec.br_type = 3'b101;
          3'b101:  w_dec.br_type = 3'b110;
          3'b110:  w_dec.br_type = 3'b011;
          3'b111:  w_dec.br_type = 3'b100;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_dec.alu_src2 = 1'b1;
        case (w_f3)
          3'b000:  w_dec.mem_write = 2'b01;
          3'b001:  w_dec.mem_write = 2'b10;
          3'b010:  w_dec.mem_write = 2'b11;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src2   = 1'b1;
        w_dec.result_src = 2'b01;
        case (w_f3)
          3'b000:  w_dec.mem_read = 3'b001;
          3'b001:  w_dec.mem_read = 3'b010;
          3'b010:  w_dec.mem_read = 3'b000;
          3'b100:  w_dec.mem_read = 3'b011;
          3'b101:  w_dec.mem_read = 3'b100;
          default: w_bad = 1'b1;
        endcase
      end
      default: w_bad = 1'b1;
    endcase

    if (w_bad || bus.in_instr[1:0] != 2'b11) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.rd  = bus.in_instr[11:7];
    w_dec.rs1 = bus.in_instr[19:15];
    w_dec.rs2 = bus.in_instr[24:20];
    w_dec.pc  = bus.in_pc;
  end

  // Ready/valid are decoded purely from the registered occupancy state
  assign bus.in_ready  = (r_state != S_FULL);
  assign bus.out_valid = (r_state != S_EMPTY);
  assign w_accept      = bus.in_valid && (r_state != S_FULL);
  assign w_pop         = (r_state != S_EMPTY) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = S_MAIN;
          w_load_main_in = 1'b1;
        end
      end
      S_MAIN: begin
        if (w_pop && w_accept) begin
          w_load_main_in = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt      = S_MAIN;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt      = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in)        r_main <= w_dec;
      else if (w_load_main_skid) r_main <= r_skid;
      if (w_load_skid)           r_skid <= w_dec;
    end
  end

  assign bus.out_reg_write   = r_main.reg_write;
  assign bus.out_alu_src1    = r_main.alu_src1;
  assign bus.out_alu_src2    = r_main.alu_src2;
  assign bus.out_mem_write   = r_main.mem_write;
  assign bus.out_mem_read    = r_main.mem_read;
  assign bus.out_result_src  = r_main.result_src;
  assign bus.out_br_type     = r_main.br_type;
  assign bus.out_alu_control = r_main.alu_control;
  assign bus.out_rd          = r_main.rd;
  assign bus.out_rs1         = r_main.rs1;
  assign bus.out_rs2         = r_main.rs2;
  assign bus.out_pc          = r_main.pc;
  assign bus.out_illegal     = r_main.illegal;

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered RV32I decode stage that replaces the combinational control unit.
- Takes the fetched instruction and PC over a valid/ready handshake and fully decodes them into the existing control bundle, plus register indices and an illegal-instruction flag.
- Holds results in a 2-entry skid buffer, so backpressure from execute never creates a combinational ready path.
- Sits between the IF/ID boundary and the execute stage.

Parameters:
- XLEN, 32, PC width in bits.
- ALUCTRL_W, 5, ALU control width; must be ≥4, and ≥5 when RV32M_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_reg_write  out  1  RegWrite.
- out_alu_src1  out  1  0=rs1, 1=PC.
- out_alu_src2  out  1  0=rs2, 1=imm.
- out_mem_write  out  2  00 none, 01 sb, 10 sh, 11 sw.
- out_mem_read  out  3  000 lw/none, 001 lb, 010 lh, 011 lbu, 100 lhu.
- out_result_src  out  2  00 ALU, 01 memory, 10 PC+4.
- out_br_type  out  3  000 none, 001 beq, 010 bne, 011 bltu, 100 bgeu, 101 blt, 110 bge, 111 jump.
- out_alu_control  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 pass-imm (lui), 5 slt, 6 xor, 7 srl, 8 sll, 9 sra, 10 sltu; 11–18 are M ops.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_pc  out  XLEN  PC of bundle.
- out_illegal  out  1  unsupported encoding.

Behaviour:
- Reset: all outputs 0 and both entries invalid. in_ready is 1 after reset is released.
- Decode is a pure function of in_instr, evaluated when the instruction is captured. No x values are ever driven; don't-care fields output 0.
- Opcode classes and their control values:
  - R-type (0110011): RegWrite=1, src1=0, src2=0.
  - OP-IMM (0010011): src2=1.
  - auipc: src1=1, src2=1, add.
  - lui: src2=1, ALU code 4.
  - jal: src1=1, src2=1, result_src=10, br_type=111.
  - jalr: src1=0, src2=1, result_src=10, br_type=111.
  - Branches: src1=1, src2=1, add, br_type per funct3.
  - Stores: src2=1, mem_write per funct3.
  - Loads: RegWrite=1, src2=1, result_src=01, mem_read per funct3.
- ALU selection:
  - funct7[5]=1 selects sub only for R-type funct3=000; addi never subtracts.
  - funct3=101 selects srl or sra by funct7[5].
  - OP-IMM shifts require funct7 = 0000000, or 0100000 for srai; any other value is illegal.
  - R-type requires funct7 ∈ {0000000, 0100000 (add/sub, srl/sra only)}.
- Illegal encodings: undefined opcode, branch funct3 010/011, store funct3 ≥011, load funct3 011/110/111, jalr funct3≠000, in_instr[1:0]≠11. Result: out_illegal=1, all control outputs 0, indices and PC still passed through.
- Handshake: a transfer occurs when valid && ready on a clock edge.
  - Latency is 1 cycle: a bundle accepted at edge N is presented with out_valid=1 after edge N.
  - Output entry (main) plus skid entry. in_ready is registered and equals !skid_valid.
  - Input accepted while main is full and out_ready=0 goes to skid.
  - When main is consumed, skid moves to main on the same edge.
  - Order is strictly FIFO; with out_ready held at 1, throughput is 1 bundle per cycle.
  - out_* stay stable while out_valid=1 and out_ready=0.
- flush=1 at an edge:
  - Both entries are invalidated; in_ready=1 next cycle.
  - A same-cycle in_valid is discarded.
  - Flush has priority over all other events.
- rst_n asserted mid-transfer: state clears immediately (asynchronously); a pending bundle is lost.

Optional Feature:
- RV32M_EN defined: R-type with funct7=0000001 decodes funct3 000–111 to ALU codes 11 mul, 12 mulh, 13 mulhsu, 14 mulhu, 15 div, 16 divu, 17 rem, 18 remu, with RegWrite=1.
- Not defined: funct7=0000001 is illegal. ALU codes 11–18 are never emitted.

Test Plan:
- Reset low then release; send `add x3,x1,x2` (0x002081B3) at PC 0x100 -> one cycle later: out_valid=1, reg_write=1, alu_control=0, rd=3, rs1=1, rs2=2, out_pc=0x100, illegal=0.
- Send `sub` (0x402081B3), then `addi x1,x0,-1` (0xFFF00093) -> alu_control=1 for sub; alu_control=0 and src2=1 for addi.
- Hold out_ready=0 while streaming `lw`, `lb`, `sw` -> lw stays in main and lb fills skid; in_ready then drops to 0 and sw is held off. Raise out_ready -> outputs in order: lw (mem_read=000, result_src=01), lb (001), sw (mem_write=11); no loss and no duplication.
- Send `bge` (funct3 101) and `jalr` -> br_type=110 for bge; br_type=111, result_src=10 for jalr. Send opcode 0x7F, then branch funct3 010 -> each gives illegal=1 with all control 0.
- Fill both entries, assert flush together with in_valid -> next cycle out_valid=0 and in_ready=1; the offered instruction never appears.
- Send mul (0x022081B3) -> alu_control=11 with RV32M_EN; illegal=1 without it.
